// File: rtl/rv32_enc_pkg.sv
// ============================================================================
//  Package      : rv32_enc_pkg
//  Description  : Opcode constants, instruction-format enum, NOP word and
//                 FSM state encoding shared by the instruction loader and the
//                 decode stage. Optional feature macro:
//                 RV32_LOADER_RANGE_CHECK_EN (immediate range checking).
//  Revision     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rv32_enc_pkg;

    // Major opcodes, bits [6:0] of the instruction word
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_ALU_I = 7'b0010011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_D     = 7'b0001011;

    // Descriptor format code; 6 and 7 are reserved and encode as NOP
    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_LOAD  = 3'd1,
        FMT_ALU_I = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_D     = 3'd5,
        FMT_RSV6  = 3'd6,
        FMT_RSV7  = 3'd7
    } fmt_e;

    // addi x0,x0,0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    // Loader session FSM
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Immediate bits the encoder needs: all 32 when range checking, else
    // only the 13 bits that can land in an encoded word.
`ifdef RV32_LOADER_RANGE_CHECK_EN
    localparam int ENC_IMM_W = 32;
`else
    localparam int ENC_IMM_W = 13;
`endif

endpackage

`default_nettype wire

// File: rtl/rv32_inst_loader_if.sv
// ============================================================================
//  Interface    : rv32_inst_loader_if
//  Description  : Descriptor stream (valid/ready) from the host plus the imem
//                 write port driven by the loader.
//                 master = host/imem side, slave = loader.
//  Revision     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface rv32_inst_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_last, in_fmt, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_fmt, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/rv32_inst_encode.sv
// ============================================================================
//  Module       : rv32_inst_encode
//  Description  : Purely combinational packer turning a field-level
//                 descriptor into an RV32 instruction word. Reserved formats
//                 produce NOP. With RV32_LOADER_RANGE_CHECK_EN defined it also
//                 flags out-of-range immediates / reserved formats and
//                 substitutes NOP for the offending word.
//  Revision     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rv32_inst_encode
    import rv32_enc_pkg::*;
(
    input  logic [2:0]           fmt,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [ENC_IMM_W-1:0] imm,
`ifdef RV32_LOADER_RANGE_CHECK_EN
    output logic                 enc_err,
`endif
    output logic [31:0]          word
);

    logic [31:0] packed_word;

    // Field packing; upper immediate bits simply fall off
    always_comb begin
        packed_word = INSN_NOP;
        case (fmt_e'(fmt))
            FMT_R:     packed_word = {funct7, rs2, rs1, funct3, rd, OPC_R};
            FMT_D:     packed_word = {funct7, rs2, rs1, funct3, rd, OPC_D};
            FMT_LOAD:  packed_word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            FMT_ALU_I: packed_word = {imm[11:0], rs1, funct3, rd, OPC_ALU_I};
            FMT_S:     packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S};
            FMT_B:     packed_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                      imm[4:1], imm[11], OPC_B};
            default:   packed_word = INSN_NOP;
        endcase
    end

`ifdef RV32_LOADER_RANGE_CHECK_EN
    logic fits_12;
    logic fits_b;

    // 12-bit signed: bits [31:11] are all copies of the sign
    assign fits_12 = (imm[31:11] == {21{imm[11]}});
    // Branch offset: 13-bit signed and even, i.e. [-4096, 4094]
    assign fits_b  = (imm[31:12] == {20{imm[12]}}) && !imm[0];

    // Per-format legality of the descriptor
    always_comb begin
        enc_err = 1'b0;
        case (fmt_e'(fmt))
            FMT_R, FMT_D:                enc_err = 1'b0;
            FMT_LOAD, FMT_ALU_I, FMT_S:  enc_err = !fits_12;
            FMT_B:                       enc_err = !fits_b;
            default:                     enc_err = 1'b1;
        endcase
    end

    assign word = enc_err ? INSN_NOP : packed_word;
`else
    assign word = packed_word;
`endif

endmodule

`default_nettype wire

// File: rtl/rv32_inst_loader.sv
// ============================================================================
//  Module       : rv32_inst_loader
//  Description  : Program loader. Accepts instruction descriptors over a
//                 valid/ready stream, encodes them and writes one word per
//                 cycle to consecutive imem byte addresses (wrapping modulo
//                 2^ADDR_W). Optional feature macro:
//                 RV32_LOADER_RANGE_CHECK_EN - sticky err on bad immediates
//                 or reserved formats; err is constant 0 otherwise.
//  Revision     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rv32_inst_loader
    import rv32_enc_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    rv32_inst_loader_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic [15:0]        wr_count,
    output logic               err
);

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       enc_word;
    logic              accept;

    assign bus.in_ready   = (state == ST_ACTIVE);
    assign accept         = (state == ST_ACTIVE) && bus.in_valid;
    assign busy           = (state != ST_IDLE);
    assign bus.imem_we    = we_reg;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = wdata_reg;

`ifdef RV32_LOADER_RANGE_CHECK_EN
    logic enc_err;
    logic err_reg;
`endif

    rv32_inst_encode u_encode (
        .fmt     (bus.in_fmt),
        .rd      (bus.in_rd),
        .rs1     (bus.in_rs1),
        .rs2     (bus.in_rs2),
        .funct3  (bus.in_funct3),
        .funct7  (bus.in_funct7),
        .imm     (bus.in_imm[ENC_IMM_W-1:0]),
`ifdef RV32_LOADER_RANGE_CHECK_EN
        .enc_err (enc_err),
`endif
        .word    (enc_word)
    );

    // Session FSM, write-address counter and registered imem write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            done      <= 1'b0;
            wr_count  <= '0;
        end else begin
            we_reg <= accept;
            done   <= accept && bus.in_last;

            if (accept) begin
                addr_reg  <= next_addr;
                wdata_reg <= enc_word;
                next_addr <= next_addr + ADDR_W'(4);
                wr_count  <= wr_count + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ACTIVE;
                        next_addr <= {base_addr[ADDR_W-1:2], 2'b00};
                        wr_count  <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (accept && bus.in_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef RV32_LOADER_RANGE_CHECK_EN
    // Sticky error: cleared by a new session, set by any bad descriptor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            err_reg <= 1'b0;
        end else if (accept && enc_err) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32_inst_loader.sv
// ============================================================================
//  Module       : tb_rv32_inst_loader
//  Description  : Self-checking bench for rv32_inst_loader: directed sessions
//                 with literal expectations plus randomized sessions checked
//                 cycle by cycle against a behavioural model.
//  Revision     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rv32_inst_loader;

    localparam int ADDR_W = 12;
`ifdef RV32_LOADER_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy;
    logic              done;
    logic [15:0]       wr_count;
    logic              err;

    rv32_inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rv32_inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference encoder built from the instruction-field rules
    function automatic logic [31:0] ref_encode(input int fmt, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] imm, output bit bad);
        logic [31:0] w;
        logic [31:0] regs;
        int v;
        v    = int'($signed(imm));
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        bad  = 1'b0;
        w    = 32'h13;
        case (fmt)
            0: w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'd51;
            5: w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'd11;
            1, 2: begin
                w   = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (32'(rd) << 7) | ((fmt == 1) ? 32'd3 : 32'd19);
                bad = (v < -2048) || (v > 2047);
            end
            3: begin
                w   = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'd35;
                bad = (v < -2048) || (v > 2047);
            end
            4: begin
                w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'd99;
                bad = (v < -4096) || (v > 4094) || ((v % 2) != 0);
            end
            default: begin
                w   = 32'h13;
                bad = 1'b1;
            end
        endcase
        bad = CHK && bad;
        if (bad) w = 32'h13;
        return w;
    endfunction

    // Behavioural model: session phase, address, count and expected outputs
    int          m_phase = 0;   // 0 idle, 1 accepting, 2 final write
    logic [11:0] m_addr  = '0;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    bit          x_we    = 1'b0;
    bit          x_done  = 1'b0;
    logic [11:0] x_addr  = '0;
    logic [31:0] x_wdata = '0;

    initial begin
        bit          acc;
        bit          bad;
        logic [31:0] w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_addr = '0; m_count = 0; m_err = 1'b0;
                x_we = 1'b0; x_done = 1'b0; x_addr = '0; x_wdata = '0;
            end else begin
                cyc++;
                acc    = (m_phase == 1) && bus.in_valid;
                x_we   = acc;
                x_done = acc && bus.in_last;
                if (acc) begin
                    w = ref_encode(int'(bus.in_fmt), bus.in_rd, bus.in_rs1, bus.in_rs2,
                                   bus.in_funct3, bus.in_funct7, bus.in_imm, bad);
                    x_addr  = m_addr;
                    x_wdata = w;
                    m_addr  = 12'((int'(m_addr) + 4) % 4096);
                    m_count = (m_count + 1) % 65536;
                    if (bad) m_err = 1'b1;
                end
                if (m_phase == 0) begin
                    if (start) begin
                        m_phase = 1;
                        m_addr  = 12'((int'(base_addr) / 4) * 4);
                        m_count = 0;
                        m_err   = 1'b0;
                    end
                end else if (m_phase == 1) begin
                    if (acc && bus.in_last) m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("imem_we", 32'(bus.imem_we), 32'(x_we));
                chk("done", 32'(done), 32'(x_done));
                chk("busy", 32'(busy), 32'(m_phase != 0));
                chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
                chk("wr_count", 32'(wr_count), 32'(m_count));
                chk("err", 32'(err), 32'(m_err));
                if (x_we) begin
                    chk("imem_addr", 32'(bus.imem_addr), 32'(x_addr));
                    chk("imem_wdata", bus.imem_wdata, x_wdata);
                end
            end
            if (bus.imem_we) begin
                wa.push_back(bus.imem_addr);
                wd.push_back(bus.imem_wdata);
                wc.push_back(cyc);
            end
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
    endtask

    task automatic do_start(input logic [11:0] base);
        @(negedge clk);
        bus.in_valid = 1'b0;
        base_addr    = base;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        base_addr    = 12'($urandom);
    endtask

    // Present a descriptor at the current negedge; returns at the next negedge
    task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input bit last, input bit rnd_start);
        int t;
        bus.in_fmt    = f;   bus.in_rd     = rd;  bus.in_rs1 = rs1;
        bus.in_rs2    = rs2; bus.in_funct3 = f3;  bus.in_funct7 = f7;
        bus.in_imm    = imm; bus.in_last   = last;
        bus.in_valid  = 1'b1;
        start         = rnd_start && ($urandom_range(0, 3) == 0);
        t = 0;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: actual=in_ready low for %0d cycles required=high", t);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = 1'b0;
        bus.in_last  = 1'($urandom);
        bus.in_imm   = $urandom;
    endtask

    // Called at the final-write negedge; returns at the first idle negedge
    task automatic finish_session();
        start = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_imm();
        int edges[10] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4097, 4096, 3};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4095) - 2048);
            2:       return 32'(edges[$urandom_range(0, 9)]);
            default: return 32'($urandom_range(0, 8191) - 4096) & 32'hFFFF_FFFE;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_fmt = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_we", 32'(bus.imem_we), 0);
        chk("rst_addr", 32'(bus.imem_addr), 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_err", 32'(err), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // add x3,x1,x2 at 0x100
        do_start(12'h100);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 1'b0);
        chk("t1_we", 32'(bus.imem_we), 1);
        chk("t1_addr", 32'(bus.imem_addr), 32'h100);
        chk("t1_data", bus.imem_wdata, 32'h002081B3);
        chk("t1_done", 32'(done), 1);
        chk("t1_count", 32'(wr_count), 1);
        finish_session();
        chk("t1_busy_drop", 32'(busy), 0);

        // addi / sw / beq stream, no bubbles
        clear_log();
        do_start(12'h000);
        send(3'd2, 5'd5, 5'd0, 5'd9, 3'd0, 7'd0, -32'sd1, 1'b0, 1'b1);
        send(3'd3, 5'd7, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 1'b1);
        send(3'd4, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b1, 1'b1);
        finish_session();
        chk("t2_nwrites", 32'(wa.size()), 3);
        chk("t2_d0", wd[0], 32'hFFF00293);
        chk("t2_d1", wd[1], 32'h0020A423);
        chk("t2_d2", wd[2], 32'hFE208EE3);
        chk("t2_a0", 32'(wa[0]), 32'h000);
        chk("t2_a2", 32'(wa[2]), 32'h008);
        chk("t2_no_bubble", 32'(wc[2] - wc[0]), 2);

        // address wrap
        clear_log();
        do_start(12'hFFC);
        send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0);
        send(3'd5, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd0, 1'b1, 1'b0);
        finish_session();
        chk("t3_a0", 32'(wa[0]), 32'hFFC);
        chk("t3_a1", 32'(wa[1]), 32'h000);

        // reserved format
        clear_log();
        do_start(12'h040);
        send(3'd7, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd5, 1'b1, 1'b0);
        finish_session();
        chk("t4_nop", wd[0], 32'h00000013);
        chk("t4_err", 32'(err), 32'(CHK));

        // odd branch offset, err held then cleared by start
        clear_log();
        do_start(12'h080);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 1'b0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 1'b0);
        finish_session();
        chk("t5_word", wd[0], CHK ? 32'h00000013 : 32'h00208163);
        chk("t5_err_held", 32'(err), 32'(CHK));
        do_start(12'h0C0);
        chk("t5_err_clr", 32'(err), 0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 1'b0);
        finish_session();

        // reset in the cycle after the 2nd of 4 accepted descriptors
        do_start(12'h200);
        send(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b0);
        send(3'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 1'b0);
        bus.in_valid = 1'b1; bus.in_last = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_we_async", 32'(bus.imem_we), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count", 32'(wr_count), 0);
        chk("t6_addr", 32'(bus.imem_addr), 0);
        chk("t6_wdata", bus.imem_wdata, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_accept", 32'(bus.imem_we), 0);
        chk("t6_idle", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        do_start(12'h300);
        send(3'd2, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 1'b0);
        send(3'd2, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b1, 1'b0);
        finish_session();

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            do_start(12'($urandom));
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                send(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'($urandom), rnd_imm(), k == n - 1, 1'b1);
                if (k != n - 1) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            finish_session();
            bus.in_valid = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.in_valid = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
